// File: rtl/vic_pkg.sv
// Shared constants and FSM state type for the vectored interrupt block.
// The interrupt controller imports the same sizes.
package vic_pkg;

    localparam int N_SRC = 31;
    localparam int ID_W = 5;
    localparam int VEC_W = 32;
    localparam logic [31:0] DEF_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } vic_state_t;

endpackage

// File: rtl/vic_vector_if.sv
// Bus bundle between the interrupt controller / CPU side and the vector unit.
// Member names follow the block's port list.
interface vic_vector_if #(
    parameter int ID_W = vic_pkg::ID_W,
    parameter int VEC_W = vic_pkg::VEC_W
);

    logic i_irq;
    logic [ID_W-1:0] i_irq_addr;
    logic o_busy;
    logic o_cpu_irq;
    logic [VEC_W-1:0] o_vector;
    logic [ID_W-1:0] o_irq_id;
    logic i_cpu_ack;
    logic i_eoi;
    logic i_tbl_we;
    logic [ID_W-1:0] i_tbl_addr;
    logic [VEC_W-1:0] i_tbl_wdata;
    logic o_lost;
    logic i_lost_clr;

    modport slave (
        input  i_irq, i_irq_addr, i_cpu_ack, i_eoi,
        input  i_tbl_we, i_tbl_addr, i_tbl_wdata, i_lost_clr,
        output o_busy, o_cpu_irq, o_vector, o_irq_id, o_lost
    );

    modport master (
        output i_irq, i_irq_addr, i_cpu_ack, i_eoi,
        output i_tbl_we, i_tbl_addr, i_tbl_wdata, i_lost_clr,
        input  o_busy, o_cpu_irq, o_vector, o_irq_id, o_lost
    );

endinterface

// File: rtl/vic_vec_table.sv
// Handler address table: synchronous write, combinational read with
// write-through so a same-cycle capture sees the new entry.
module vic_vec_table #(
    parameter int N_SRC = vic_pkg::N_SRC,
    parameter int ID_W = vic_pkg::ID_W,
    parameter int VEC_W = vic_pkg::VEC_W,
    parameter logic [VEC_W-1:0] DEF_VEC = vic_pkg::DEF_VEC
) (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic [ID_W-1:0] waddr,
    input  logic [VEC_W-1:0] wdata,
    input  logic [ID_W-1:0] raddr,
    output logic [VEC_W-1:0] rdata
);

    localparam logic [ID_W:0] LIM = N_SRC[ID_W:0];

    logic [VEC_W-1:0] tbl [N_SRC];
    logic w_ok;
    logic r_ok;

    assign w_ok = {1'b0, waddr} < LIM;
    assign r_ok = {1'b0, raddr} < LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                tbl[i] <= '0;
            end
        end else if (we && w_ok) begin
            tbl[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = DEF_VEC;
        if (r_ok) begin
            if (we && waddr == raddr) begin
                rdata = wdata;
            end else begin
                rdata = tbl[raddr];
            end
        end
    end

endmodule

// File: rtl/vic_vector.sv
// Vectored interrupt front end: captures a controller pulse, looks up the
// handler address, and walks IDLE -> REQ -> SERVICE with the CPU.
module vic_vector #(
    parameter int N_SRC = vic_pkg::N_SRC,
    parameter int ID_W = vic_pkg::ID_W,
    parameter int VEC_W = vic_pkg::VEC_W,
    parameter logic [VEC_W-1:0] DEF_VEC = vic_pkg::DEF_VEC
) (
    input  logic i_clk,
    input  logic i_rst,
    vic_vector_if.slave bus
);

    import vic_pkg::*;

    vic_state_t state;
    logic irq_q;
    logic cap;
    logic busy;
    logic cpu_irq;
    logic lost;
    logic [VEC_W-1:0] vector;
    logic [ID_W-1:0] irq_id;
    logic [VEC_W-1:0] lookup;

    vic_vec_table #(
        .N_SRC(N_SRC),
        .ID_W(ID_W),
        .VEC_W(VEC_W),
        .DEF_VEC(DEF_VEC)
    ) u_table (
        .clk(i_clk),
        .rst(i_rst),
        .we(bus.i_tbl_we),
        .waddr(bus.i_tbl_addr),
        .wdata(bus.i_tbl_wdata),
        .raddr(bus.i_irq_addr),
        .rdata(lookup)
    );

    // Rising edge only: a long pulse is one request.
    assign cap = bus.i_irq & ~irq_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            irq_q <= 1'b0;
            busy <= 1'b0;
            cpu_irq <= 1'b0;
            lost <= 1'b0;
            vector <= '0;
            irq_id <= '0;
        end else begin
            irq_q <= bus.i_irq;
            if (cap && state != IDLE) begin
                lost <= 1'b1;
            end else if (bus.i_lost_clr) begin
                lost <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cap) begin
                        irq_id <= bus.i_irq_addr;
                        vector <= lookup;
                        cpu_irq <= 1'b1;
                        busy <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.i_cpu_ack) begin
                        cpu_irq <= 1'b0;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.i_eoi) begin
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    cpu_irq <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = busy;
    assign bus.o_cpu_irq = cpu_irq;
    assign bus.o_vector = vector;
    assign bus.o_irq_id = irq_id;
    assign bus.o_lost = lost;

endmodule

// File: tb/tb_vic_vector.sv
// Bench for vic_vector: scoreboard of expected vectors popped on each
// CPU request, plus directed state checks.
module tb_vic_vector;

    typedef struct packed {
        logic [4:0] id;
        logic [31:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    logic prev_cpu = 1'b0;

    vic_vector_if #(.ID_W(5), .VEC_W(32)) bus ();

    vic_vector dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Monitor: every new CPU request must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_cpu_irq && !prev_cpu) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected got id %0d want none",
                         bus.o_irq_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_vector", bus.o_vector, e.vec);
                chk("sb_id", {27'd0, bus.o_irq_id}, {27'd0, e.id});
                chk("sb_busy", {31'd0, bus.o_busy}, 32'd1);
            end
        end
        prev_cpu = bus.o_cpu_irq;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [4:0] id, input logic [31:0] vec);
        exp_q.push_back('{id: id, vec: vec});
        bus.i_irq = 1'b1;
        bus.i_irq_addr = id;
        tick();
        bus.i_irq = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.i_tbl_we = 1'b1;
        bus.i_tbl_addr = a;
        bus.i_tbl_wdata = d;
        tick();
        bus.i_tbl_we = 1'b0;
    endtask

    task automatic ack();
        bus.i_cpu_ack = 1'b1;
        tick();
        bus.i_cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        bus.i_eoi = 1'b1;
        tick();
        bus.i_eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_irq = 1'b0;
        bus.i_irq_addr = '0;
        bus.i_cpu_ack = 1'b0;
        bus.i_eoi = 1'b0;
        bus.i_tbl_we = 1'b0;
        bus.i_tbl_addr = '0;
        bus.i_tbl_wdata = '0;
        bus.i_lost_clr = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rst_cpu", {31'd0, bus.o_cpu_irq}, 32'd0);
        chk("rst_lost", {31'd0, bus.o_lost}, 32'd0);
        chk("rst_vec", bus.o_vector, 32'd0);

        // Basic request / ack / eoi with a lost pulse in SERVICE
        wr(5'd3, 32'h0000_1040);
        pulse(5'd3, 32'h0000_1040);
        tick(3);
        ack();
        chk("ack_cpu", {31'd0, bus.o_cpu_irq}, 32'd0);
        chk("ack_busy", {31'd0, bus.o_busy}, 32'd1);
        tick(4);
        bus.i_irq = 1'b1;
        bus.i_irq_addr = 5'd7;
        tick();
        bus.i_irq = 1'b0;
        chk("lost_set", {31'd0, bus.o_lost}, 32'd1);
        chk("lost_id", {27'd0, bus.o_irq_id}, 32'd3);
        chk("lost_vec", bus.o_vector, 32'h0000_1040);
        tick(4);
        chk("svc_busy", {31'd0, bus.o_busy}, 32'd1);
        eoi();
        chk("eoi_busy", {31'd0, bus.o_busy}, 32'd0);
        bus.i_lost_clr = 1'b1;
        tick();
        bus.i_lost_clr = 1'b0;
        chk("lost_clr", {31'd0, bus.o_lost}, 32'd0);
        ack();
        chk("idle_ack", {31'd0, bus.o_cpu_irq | bus.o_busy}, 32'd0);

        // Same-cycle write and capture, eoi ignored in REQ
        bus.i_tbl_we = 1'b1;
        bus.i_tbl_addr = 5'd5;
        bus.i_tbl_wdata = 32'hDEAD_BEEF;
        pulse(5'd5, 32'hDEAD_BEEF);
        bus.i_tbl_we = 1'b0;
        eoi();
        chk("req_eoi", {30'd0, bus.o_busy, bus.o_cpu_irq}, 32'd3);
        ack();
        wr(5'd5, 32'h0000_1234);
        chk("svc_wr_vec", bus.o_vector, 32'hDEAD_BEEF);
        eoi();
        // Back-to-back capture right after busy falls
        pulse(5'd5, 32'h0000_1234);
        chk("b2b_cpu", {31'd0, bus.o_cpu_irq}, 32'd1);
        ack();
        eoi();

        // Long pulse counts once
        exp_q.push_back('{id: 5'd2, vec: 32'd0});
        bus.i_irq = 1'b1;
        bus.i_irq_addr = 5'd2;
        tick(5);
        bus.i_irq = 1'b0;
        chk("long_lost", {31'd0, bus.o_lost}, 32'd0);
        tick();
        // Loss and clear in the same cycle: set wins
        bus.i_irq = 1'b1;
        bus.i_lost_clr = 1'b1;
        tick();
        bus.i_irq = 1'b0;
        bus.i_lost_clr = 1'b0;
        chk("set_wins", {31'd0, bus.o_lost}, 32'd1);
        ack();
        eoi();

        // Reset during REQ
        pulse(5'd3, 32'h0000_1040);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out", {bus.o_vector[29:0], bus.o_busy, bus.o_cpu_irq},
            32'd0);
        chk("mrst_lost", {27'd0, bus.o_irq_id}, 32'd0);
        chk("mrst_lostf", {31'd0, bus.o_lost}, 32'd0);
        pulse(5'd3, 32'd0);
        ack();
        eoi();
        wr(5'd31, 32'hFFFF_FFFF);
        pulse(5'd31, 32'h0000_0000);
        chk("def_id", {27'd0, bus.o_irq_id}, 32'd31);
        ack();
        eoi();
        tick(2);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
